// File: rtl/fp16_fma_dot_accum.sv
// fp16_fma_dot_accum
//   Sequencer that feeds an external 4-cycle FP16 FMA so that a stream of
//   (a, b) pairs turns into a single FP16 dot product. While a vector is
//   streaming, one FMA is issued per cycle and four interleaved partial sums
//   circulate through the FMA pipeline. After the last pair, the four partials
//   are drained and reduced as (p0*1+p1), (p2*1+p3), then (s0*1+s1).
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand-pair handshake; in_a, in_b, in_last
//   in_bias              (only with FMA_DOT_BIAS_EN) addend of the first issue
//   fma_in_valid, fma_a, fma_b, fma_c   issue port towards the FMA
//   fma_out_valid, fma_out              return port from the FMA
//   res_valid/res_ready, res_data       dot-product result handshake
//
// Build option
//   FMA_DOT_BIAS_EN  adds in_bias; the result becomes bias + sum(a*b).
module fp16_fma_dot_accum #(
    parameter int FMA_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
`ifdef FMA_DOT_BIAS_EN
    input  logic [15:0] in_bias,
`endif
    output logic        fma_in_valid,
    output logic [15:0] fma_a,
    output logic [15:0] fma_b,
    output logic [15:0] fma_c,
    input  logic        fma_out_valid,
    input  logic [15:0] fma_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data
);

    localparam logic [15:0] ONE  = 16'h3C00;
    localparam logic [15:0] ZERO = 16'h0000;
    localparam logic [2:0]  RING = 3'(FMA_LATENCY);
    localparam logic [1:0]  LAST_DRAIN = 2'(FMA_LATENCY - 1);

    typedef enum logic [3:0] {
        IDLE, ACCUM, DRAIN, RED0, RED1, WAIT1, RED2, WAIT2, OUT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  issue_cnt_q;
    logic [1:0]  cnt_q;
    logic [15:0] p_q [4];
    logic [15:0] s_q [2];
    logic [15:0] res_q;

    logic        accept;
    logic [15:0] first_c;

`ifdef FMA_DOT_BIAS_EN
    assign first_c = in_bias;
`else
    assign first_c = ZERO;
`endif

    // rst gates in_ready so that every output reads 0 while reset is held,
    // even though the state register already sits in IDLE.
    assign in_ready  = ~rst & ((state_q == IDLE) | (state_q == ACCUM));
    assign accept    = in_valid & in_ready;
    assign res_valid = (state_q == OUT);
    assign res_data  = res_q;

    // Issue port: combinational from state, inputs and the FMA return.
    always_comb begin
        fma_in_valid = 1'b0;
        fma_a        = ZERO;
        fma_b        = ZERO;
        fma_c        = ZERO;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    fma_in_valid = 1'b1;
                    fma_a        = in_a;
                    fma_b        = in_b;
                    fma_c        = first_c;
                end
            end
            ACCUM: begin
                // Bubbles still issue 0*0+c so each partial keeps rotating.
                fma_in_valid = 1'b1;
                if (accept) begin
                    fma_a = in_a;
                    fma_b = in_b;
                end
                if (issue_cnt_q >= RING) begin
                    fma_c = fma_out;
                end
            end
            RED0: begin
                fma_in_valid = 1'b1;
                fma_a        = p_q[0];
                fma_b        = ONE;
                fma_c        = p_q[1];
            end
            RED1: begin
                fma_in_valid = 1'b1;
                fma_a        = p_q[2];
                fma_b        = ONE;
                fma_c        = p_q[3];
            end
            RED2: begin
                fma_in_valid = 1'b1;
                fma_a        = s_q[0];
                fma_b        = ONE;
                fma_c        = s_q[1];
            end
            default: begin
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = in_last ? DRAIN : ACCUM;
            ACCUM: if (accept && in_last) state_d = DRAIN;
            DRAIN: if (cnt_q == LAST_DRAIN) state_d = RED0;
            RED0:  state_d = RED1;
            RED1:  state_d = WAIT1;
            WAIT1: if (fma_out_valid && cnt_q[0]) state_d = RED2;
            RED2:  state_d = WAIT2;
            WAIT2: if (fma_out_valid) state_d = OUT;
            OUT:   if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < 4; i++) p_q[i] <= ZERO;
            s_q[0]      <= ZERO;
            s_q[1]      <= ZERO;
            res_q       <= ZERO;
        end else begin
            state_q <= state_d;
            // cnt_q only counts inside DRAIN and WAIT1; it is zero on entry.
            cnt_q   <= '0;
            unique case (state_q)
                IDLE: begin
                    if (accept) issue_cnt_q <= 3'd1;
                end
                ACCUM: begin
                    if (issue_cnt_q < RING) issue_cnt_q <= issue_cnt_q + 3'd1;
                end
                DRAIN: begin
                    // Missing partials of short vectors come back as zero.
                    p_q[cnt_q] <= fma_out_valid ? fma_out : ZERO;
                    cnt_q      <= cnt_q + 2'd1;
                end
                WAIT1: begin
                    if (fma_out_valid) begin
                        s_q[cnt_q[0]] <= fma_out;
                        cnt_q         <= cnt_q + 2'd1;
                    end
                end
                WAIT2: begin
                    if (fma_out_valid) res_q <= fma_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_fma_dot_accum.sv
module tb_fp16_fma_dot_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        in_last = 1'b0;
    logic [15:0] in_bias = 16'h0;
    logic        fma_in_valid;
    logic [15:0] fma_a, fma_b, fma_c;
    logic        fma_out_valid;
    logic [15:0] fma_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp16_fma_dot_accum dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
`ifdef FMA_DOT_BIAS_EN
        .in_bias      (in_bias),
`endif
        .fma_in_valid (fma_in_valid),
        .fma_a        (fma_a),
        .fma_b        (fma_b),
        .fma_c        (fma_c),
        .fma_out_valid(fma_out_valid),
        .fma_out      (fma_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
    );

    // ---------------- FP16 helpers (value-level, round to nearest even) ----
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        real r;
        if (e == 0) r = real'(m) * pow2(-24);
        else        r = real'(1024 + m) * pow2(e - 25);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real  a, frac, rem;
        int   e, mi;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        frac = (a - 1.0) * 1024.0;
        mi   = $rtoi(frac);
        rem  = frac - real'(mi);
        if (rem > 0.5 || (rem == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 1024) begin mi = 0; e++; end
        return {s, 5'(e + 15), 10'(mi)};
    endfunction

    // ---------------- FMA model: 4-cycle latency, not reset -----------------
    logic [3:0]  pv = 4'b0;
    logic [15:0] pd [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], fma_in_valid};
        pd[0] <= r2h(h2r(fma_a) * h2r(fma_b) + h2r(fma_c));
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign fma_out_valid = pv[3];
    assign fma_out       = pv[3] ? pd[3] : 16'h5A5A;  // garbage when not valid

    // ---------------- checking ----------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          qgap[$];

    // Plays the queued vector, then checks latency, in_ready, hold and result.
    // Entered and left just after a rising edge.
    task automatic run_vec(input string name, input int hold, input logic [15:0] exp,
                           input logic [15:0] bias);
        int          L, R, k, bad;
        bit          seen;
        logic [15:0] held;
        L = 0;
        for (int i = 0; i < qa.size(); i++) begin
            for (int g = 0; g < qgap[i]; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (i > 0) begin
                    chk({name, " bubble valid"}, {31'b0, fma_in_valid}, 32'd1);
                    chk({name, " bubble ab"}, {fma_a, fma_b}, 32'd0);
                end
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_a     = qa[i];
            in_b     = qb[i];
            in_last  = (i == qa.size() - 1);
            in_bias  = bias;
            @(negedge clk);
            chk({name, " ready on accept"}, {31'b0, in_ready}, 32'd1);
            L = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        seen = 0; k = 0; bad = 0; R = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1;
                R    = cyc;
            end else begin
                if (in_ready) bad++;
                k++;
                @(posedge clk); #1;
            end
        end
        chk({name, " ready low while busy"}, bad, 0);
        chk({name, " result arrived"}, {31'b0, seen}, 32'd1);
        if (!seen) begin
            @(posedge clk); #1;
            return;
        end
        chk({name, " latency"}, R - L, 16);
        held = res_data;
        bad  = 0;
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (res_data !== held || res_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        chk({name, " hold stable"}, bad, 0);
        chk({name, " res_data"}, {16'b0, res_data}, {16'b0, exp});
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({name, " idle res_valid"}, {31'b0, res_valid}, 32'd0);
        chk({name, " idle in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic load_uniform(input int n, input int gap, input logic [15:0] a,
                                input logic [15:0] b);
        qa.delete(); qb.delete(); qgap.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(a);
            qb.push_back(b);
            qgap.push_back(i == 0 ? 0 : gap);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({name, " fma_in_valid"}, {31'b0, fma_in_valid}, 32'd0);
        chk({name, " fma_ab"}, {fma_a, fma_b}, 32'd0);
        chk({name, " fma_c"}, {16'b0, fma_c}, 32'd0);
        chk({name, " res_valid"}, {31'b0, res_valid}, 32'd0);
        chk({name, " res_data"}, {16'b0, res_data}, 32'd0);
    endtask

    typedef struct {
        string       name;
        int          n;
        int          gap;
        int          hold;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"single 2x3",   1, 0, 0,  16'h4000, 16'h4200, 16'h4600};
        tbl[1] = '{"eight ones",   8, 0, 0,  16'h3C00, 16'h3C00, 16'h4800};
        tbl[2] = '{"eight gapped", 8, 1, 0,  16'h3C00, 16'h3C00, 16'h4800};
        tbl[3] = '{"eight hold10", 8, 0, 10, 16'h3C00, 16'h3C00, 16'h4800};
        tbl[4] = '{"three 1.5x2",  3, 0, 1,  16'h3E00, 16'h4000, 16'h4880};
        tbl[5] = '{"two -1x3",     2, 2, 0,  16'hBC00, 16'h4200, 16'hC600};
        tbl[6] = '{"five halves",  5, 0, 2,  16'h3800, 16'h3800, 16'h3D00};
        tbl[7] = '{"four 2x2",     4, 1, 0,  16'h4000, 16'h4000, 16'h4C00};

        // Reset state, with in_valid asserted to show nothing leaks through.
        rst = 1'b1;
        in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00; in_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        in_valid = 1'b0; in_last = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) begin
            load_uniform(tbl[t].n, tbl[t].gap, tbl[t].a, tbl[t].b);
            run_vec(tbl[t].name, tbl[t].hold, tbl[t].exp, 16'h0000);
        end

        // Reset in the middle of a 6-element vector, then a fresh vector.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00; in_last = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid reset");
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("after reset in_ready", {31'b0, in_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        load_uniform(1, 0, 16'h3C00, 16'h4000);
        run_vec("fresh after reset", 0, 16'h4000, 16'h0000);

`ifdef FMA_DOT_BIAS_EN
        load_uniform(1, 0, 16'h3C00, 16'h3C00);
        run_vec("bias one", 0, 16'h4000, 16'h3C00);
`endif

        // Randomized vectors of exactly representable values against a
        // plain sum-of-products reference.
        for (int v = 0; v < 20; v++) begin
            int  n;
            real sum;
            n = int'($urandom_range(1, 12));
            qa.delete(); qb.delete(); qgap.delete();
            sum = 0.0;
            for (int i = 0; i < n; i++) begin
                real ra, rb;
                ra = real'(int'($urandom_range(0, 12)) - 6) / 2.0;
                rb = real'(int'($urandom_range(0, 12)) - 6) / 2.0;
                qa.push_back(r2h(ra));
                qb.push_back(r2h(rb));
                qgap.push_back(i == 0 ? 0 : int'($urandom_range(0, 2)));
                sum = sum + ra * rb;
            end
            run_vec($sformatf("random %0d", v), int'($urandom_range(0, 3)), r2h(sum), 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
